// File: rtl/credit_pkg.sv
// Shared constants and helpers for credit-based valid-only links.
// Latency: n/a (package only).
// Backpressure: n/a; keeps sender and skid receivers agreeing on depth.
package credit_pkg;

  // Default receiver depth; the sender starts with this many credits.
  localparam int DEFAULT_CREDITS = 3;
  // Default register stages between source acceptance and tx_valid.
  localparam int DEFAULT_LATENCY = 1;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int CREDIT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/valid_delay_pipe.sv
// Pure shift register of valid+data beats with no stall capability.
// Latency: STAGES cycles from in_vld_i to out_vld_o.
// Backpressure: none; a non-valid input cycle shifts in a bubble.
module valid_delay_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  dat_d [STAGES];

  // Next state: stage 0 takes the input, every later stage takes its predecessor.
  always_comb begin
    vld_d[0] = in_vld_i;
    dat_d[0] = in_dat_i;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Valid bits are reset so in-flight beats are dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Data carries no reset; it is only meaningful alongside a set valid bit.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < STAGES; i++) dat_q[i] <= dat_d[i];
  end

  assign out_vld_o = vld_q[STAGES-1];
  assign out_dat_o = dat_q[STAGES-1];

endmodule

// File: rtl/credit_sender.sv
// Credit-tracked sender: valid/ready source in, valid-only stream out to a skid receiver.
// Latency: LATENCY cycles from the accepting edge to tx_valid.
// Backpressure: src_ready is low when no receiver credits remain; tx side has none.
module credit_sender
  import credit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CREDITS = DEFAULT_CREDITS,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [WIDTH-1:0]              src_data,
  output logic                          tx_valid,
  output logic [WIDTH-1:0]              tx_data,
  input  logic                          credit_return,
  output logic [CREDIT_W(CREDITS)-1:0]  credits_avail,
  output logic                          err_credit_ovf
);

  localparam int            CW       = CREDIT_W(CREDITS);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;
  logic          issue;

  // Ready depends on registered credits only, so there is no path from credit_return.
  assign src_ready = (credits_q != '0);
  assign issue     = src_valid && src_ready;

  // Credit count: minus one per issue, plus one per return; a surplus return is flagged.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (issue && !credit_return) begin
      credits_d = credits_q - CRED_ONE;
    end else if (!issue && credit_return) begin
      if (credits_q == CRED_MAX) err_d = 1'b1;
      else                       credits_d = credits_q + CRED_ONE;
    end
  end

  // Credit and sticky-error registers; returns during reset are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  valid_delay_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (LATENCY)
  ) u_pipe (
    .clk_i     (clock),
    .rst_i     (reset),
    .in_vld_i  (issue),
    .in_dat_i  (src_data),
    .out_vld_o (tx_valid),
    .out_dat_o (tx_data)
  );

  assign credits_avail  = credits_q;
  assign err_credit_ovf = err_q;

  // Issue is gated by src_ready, so the count can never go below zero.
  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    issue |-> (credits_q != '0));

  // Surplus returns are absorbed by the error flag, never by the counter.
  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    credits_q <= CRED_MAX);

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: vector table, sustained stream, LATENCY=3 reset flush.
// Latency: n/a.
// Backpressure: n/a.
module tb_credit_sender;
  import credit_pkg::*;

  localparam int W  = 32;
  localparam int CW = CREDIT_W(DEFAULT_CREDITS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic          sv1, src_ready1, tx_valid1, cr1, err1;
  logic [W-1:0]  sd1, tx_data1;
  logic [CW-1:0] credits1;
  // LATENCY=3 instance
  logic          sv3, src_ready3, tx_valid3, cr3, err3;
  logic [W-1:0]  sd3, tx_data3;
  logic [CW-1:0] credits3;

  credit_sender #(.WIDTH(W), .CREDITS(3), .LATENCY(1)) u_dut1 (
    .clock(clk), .reset(reset), .src_valid(sv1), .src_ready(src_ready1), .src_data(sd1),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .credit_return(cr1),
    .credits_avail(credits1), .err_credit_ovf(err1));

  credit_sender #(.WIDTH(W), .CREDITS(3), .LATENCY(3)) u_dut3 (
    .clock(clk), .reset(reset), .src_valid(sv3), .src_ready(src_ready3), .src_data(sd3),
    .tx_valid(tx_valid3), .tx_data(tx_data3), .credit_return(cr3),
    .credits_avail(credits3), .err_credit_ovf(err3));

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb_q[$];
  int occ = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and receiver-occupancy model for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      occ = 0;
    end else begin
      if (tx_valid1) begin
        check("rx_has_room", 64'(occ < 3), 64'd1);
        occ++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_tx: got tx_data 0x%0h, want no beat at %0t", tx_data1, $time);
        end else begin
          check("sb_tx_data", 64'(tx_data1), 64'(sb_q.pop_front()));
        end
      end
      if (cr1 && occ > 0) occ--;
      if (sv1 && src_ready1) sb_q.push_back(sd1);
    end
  end

  typedef struct {
    logic          sv;
    logic [W-1:0]  d;
    logic          cr;
    logic          e_rdy;
    logic [CW-1:0] e_cred;
    logic          e_tv;
    logic [W-1:0]  e_dat;
    logic          e_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  function automatic vec_t mk(input logic sv, input logic [W-1:0] d, input logic cr,
                              input logic rdy, input logic [CW-1:0] cred, input logic tv,
                              input logic [W-1:0] dat, input logic err);
    vec_t v;
    v.sv = sv; v.d = d; v.cr = cr;
    v.e_rdy = rdy; v.e_cred = cred; v.e_tv = tv; v.e_dat = dat; v.e_err = err;
    return v;
  endfunction

  // Watchdog: the run is a fixed number of cycles, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, stalls, tv_cnt, first_tv, last_tv, saw_tv3;
    logic prev_tv;

    // Expected outputs are sampled in the same cycle the inputs are applied.
    vt[0]  = mk(1'b1, 32'h11, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0,  1'b0);
    vt[1]  = mk(1'b1, 32'h22, 1'b0, 1'b1, 2'd2, 1'b1, 32'h11, 1'b0);
    vt[2]  = mk(1'b1, 32'h33, 1'b0, 1'b1, 2'd1, 1'b1, 32'h22, 1'b0);
    vt[3]  = mk(1'b1, 32'h44, 1'b0, 1'b0, 2'd0, 1'b1, 32'h33, 1'b0);
    vt[4]  = mk(1'b1, 32'h44, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0);
    vt[5]  = mk(1'b1, 32'h44, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0);
    vt[6]  = mk(1'b1, 32'h44, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,  1'b0);
    vt[7]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 1'b1, 32'h44, 1'b0);
    vt[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b0, 32'h0,  1'b0);
    vt[9]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 2'd1, 1'b0, 32'h0,  1'b0);
    vt[10] = mk(1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 1'b0, 32'h0,  1'b0);
    vt[11] = mk(1'b1, 32'h55, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0,  1'b0);
    vt[12] = mk(1'b1, 32'h66, 1'b1, 1'b1, 2'd2, 1'b1, 32'h55, 1'b0);
    vt[13] = mk(1'b0, 32'h0,  1'b1, 1'b1, 2'd2, 1'b1, 32'h66, 1'b0);
    vt[14] = mk(1'b0, 32'h0,  1'b1, 1'b1, 2'd3, 1'b0, 32'h0,  1'b0);
    vt[15] = mk(1'b0, 32'h0,  1'b0, 1'b1, 2'd3, 1'b0, 32'h0,  1'b1);
    vt[16] = mk(1'b0, 32'h0,  1'b0, 1'b1, 2'd3, 1'b0, 32'h0,  1'b1);

    reset = 1'b1;
    sv1 = 1'b0; sd1 = '0; cr1 = 1'b0;
    sv3 = 1'b0; sd3 = '0; cr3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    repeat (10) cyc();
    @(negedge clk);
    check("idle_tx_valid", 64'(tx_valid1), 64'd0);
    check("idle_src_ready", 64'(src_ready1), 64'd1);
    check("idle_credits", 64'(credits1), 64'd3);
    check("idle_err", 64'(err1), 64'd0);
    check("idle3_credits", 64'(credits3), 64'd3);

    // Vector table: stall on credits, single return, issue+return, overflow
    for (int i = 0; i < NV; i++) begin
      cyc();
      sv1 = vt[i].sv; sd1 = vt[i].d; cr1 = vt[i].cr;
      @(negedge clk);
      check($sformatf("v%0d_src_ready", i), 64'(src_ready1), 64'(vt[i].e_rdy));
      check($sformatf("v%0d_credits", i), 64'(credits1), 64'(vt[i].e_cred));
      check($sformatf("v%0d_tx_valid", i), 64'(tx_valid1), 64'(vt[i].e_tv));
      if (vt[i].e_tv) check($sformatf("v%0d_tx_data", i), 64'(tx_data1), 64'(vt[i].e_dat));
      check($sformatf("v%0d_err", i), 64'(err1), 64'(vt[i].e_err));
    end

    // Sustained stream: receiver pops each beat one cycle after it arrives
    nxt = 0; stalls = 0; tv_cnt = 0; first_tv = -1; last_tv = -1; prev_tv = 1'b0;
    for (int c = 0; c < 115; c++) begin
      cyc();
      sv1 = (nxt < 100);
      sd1 = 32'h100 + 32'(nxt);
      cr1 = prev_tv;
      @(negedge clk);
      if (sv1) begin
        if (src_ready1) nxt++;
        else            stalls++;
      end
      if (tx_valid1) begin
        tv_cnt++;
        if (first_tv < 0) first_tv = c;
        last_tv = c;
      end
      prev_tv = tx_valid1;
    end
    check("stream_accepted", 64'(nxt), 64'd100);
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_tx_count", 64'(tv_cnt), 64'd100);
    check("stream_tx_span", 64'(last_tv - first_tv), 64'd99);
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);
    check("stream_credits_end", 64'(credits1), 64'd3);
    check("stream_err_sticky", 64'(err1), 64'd1);

    // LATENCY=3: single beat appears exactly three cycles after acceptance
    cyc(); sv3 = 1'b1; sd3 = 32'hB0;
    @(negedge clk); check("l3_ready", 64'(src_ready3), 64'd1);
    cyc(); sv3 = 1'b0;
    @(negedge clk); check("l3_tx_e1", 64'(tx_valid3), 64'd0);
    cyc();
    @(negedge clk); check("l3_tx_e2", 64'(tx_valid3), 64'd0);
    cyc();
    @(negedge clk);
    check("l3_tx_e3", 64'(tx_valid3), 64'd1);
    check("l3_tx_data", 64'(tx_data3), 64'hB0);
    cyc(); cr3 = 1'b1;
    @(negedge clk);
    check("l3_tx_e4", 64'(tx_valid3), 64'd0);
    check("l3_credits_out", 64'(credits3), 64'd2);
    cyc(); cr3 = 1'b0;
    @(negedge clk); check("l3_credits_back", 64'(credits3), 64'd3);

    // LATENCY=3: reset with two beats in flight; return during reset is ignored
    cyc(); sv3 = 1'b1; sd3 = 32'hA1;
    cyc(); sv3 = 1'b1; sd3 = 32'hA2;
    cyc(); sv3 = 1'b0; reset = 1'b1; cr3 = 1'b1;
    @(negedge clk);
    check("rst_pre_credits3", 64'(credits3), 64'd1);
    check("rst_pre_tx3", 64'(tx_valid3), 64'd0);
    cyc(); reset = 1'b0; cr3 = 1'b0;
    @(negedge clk);
    check("rst_post_credits3", 64'(credits3), 64'd3);
    check("rst_post_err3", 64'(err3), 64'd0);
    check("rst_post_tx3", 64'(tx_valid3), 64'd0);
    check("rst_post_credits1", 64'(credits1), 64'd3);
    check("rst_post_err1", 64'(err1), 64'd0);
    check("rst_post_tx1", 64'(tx_valid1), 64'd0);
    saw_tv3 = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      @(negedge clk);
      if (tx_valid3) saw_tv3++;
    end
    check("rst_flushed_tx3", 64'(saw_tv3), 64'd0);
    check("rst_flushed_credits3", 64'(credits3), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
